// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S DAC transmit path.
package i2s_pkg;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_FIFO_DEPTH = 8;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Per-channel synchronous sample FIFO; a pop on empty yields zero and flags underflow.
module i2s_tx_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (cnt == DEPTH_CNT);
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign underflow = pop && empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: buffers left/right samples and shifts them out on codec BCLK/DACLRCK.
// Define I2S_DAC_TX_LJ_EN for left-justified framing (no one-bit delay after the LRCK edge).
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_sink_data,
    input  logic                  left_sink_valid,
    output logic                  left_sink_ready,
    input  logic [DATA_WIDTH-1:0] right_sink_data,
    input  logic                  right_sink_valid,
    output logic                  right_sink_ready,
    input  logic                  BCLK,
    input  logic                  DACLRCK,
    output logic                  DACDAT,
    output logic                  underflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] BIT_MAX = CW'(DATA_WIDTH);

    logic                  bclk_q1, bclk_q2;
    logic                  lrck_q1, lrck_q2;
    logic                  bclk_fall;
    logic                  lrck_cur;
    logic                  lrck_q;
    logic                  lrck_seen;
    logic                  slot_start;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    logic                  left_full, right_full;
    logic                  left_empty, right_empty;
    logic                  left_pop, right_pop;
    logic                  left_under, right_under;
    logic [DATA_WIDTH-1:0] left_pop_data, right_pop_data;
    logic [DATA_WIDTH-1:0] popped;
    logic [$clog2(FIFO_DEPTH):0] left_count, right_count;
    logic                  unused_fifo_status;

    assign bclk_fall  = bclk_q2 & ~bclk_q1;
    assign lrck_cur   = lrck_q2;
    assign slot_start = bclk_fall && lrck_seen && (lrck_cur != lrck_q);
    assign left_pop   = slot_start && (lrck_cur == LRCK_LEFT);
    assign right_pop  = slot_start && (lrck_cur == LRCK_RIGHT);
    assign popped     = (lrck_cur == LRCK_RIGHT) ? right_pop_data : left_pop_data;

    assign left_sink_ready  = !left_full;
    assign right_sink_ready = !right_full;

    assign unused_fifo_status = ^{left_count, right_count, left_empty, right_empty};

    i2s_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_left_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (left_sink_valid),
        .push_data (left_sink_data),
        .pop       (left_pop),
        .pop_data  (left_pop_data),
        .full      (left_full),
        .empty     (left_empty),
        .count     (left_count),
        .underflow (left_under)
    );

    i2s_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_right_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (right_sink_valid),
        .push_data (right_sink_data),
        .pop       (right_pop),
        .pop_data  (right_pop_data),
        .full      (right_full),
        .empty     (right_empty),
        .count     (right_count),
        .underflow (right_under)
    );

    // The very first BCLK fall only learns the current LRCK level, so a slot is never started mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_q1   <= 1'b0;
            bclk_q2   <= 1'b0;
            lrck_q1   <= 1'b0;
            lrck_q2   <= 1'b0;
            lrck_q    <= 1'b0;
            lrck_seen <= 1'b0;
            bit_cnt   <= BIT_MAX;
            shreg     <= '0;
            DACDAT    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            bclk_q1 <= BCLK;
            bclk_q2 <= bclk_q1;
            lrck_q1 <= DACLRCK;
            lrck_q2 <= lrck_q1;
            if (bclk_fall) begin
                lrck_q    <= lrck_cur;
                lrck_seen <= 1'b1;
                if (slot_start) begin
                    if (left_under || right_under) begin
                        underflow <= 1'b1;
                    end
`ifdef I2S_DAC_TX_LJ_EN
                    DACDAT  <= popped[DATA_WIDTH-1];
                    shreg   <= {popped[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt <= CW'(1);
`else
                    DACDAT  <= 1'b0;
                    shreg   <= popped;
                    bit_cnt <= '0;
`endif
                end else if (bit_cnt < BIT_MAX) begin
                    DACDAT  <= shreg[DATA_WIDTH-1];
                    shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed self-checking bench for i2s_dac_tx; follows I2S_DAC_TX_LJ_EN for expected framing.
module tb_i2s_dac_tx;
    import i2s_pkg::*;

    localparam int DW = 24;

    logic    clk = 1'b0;
    logic    reset;
    sample_t left_sink_data, right_sink_data;
    logic    left_sink_valid, right_sink_valid;
    logic    left_sink_ready, right_sink_ready;
    logic    BCLK, DACLRCK;
    logic    DACDAT;
    logic    underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    i2s_dac_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .left_sink_data   (left_sink_data),
        .left_sink_valid  (left_sink_valid),
        .left_sink_ready  (left_sink_ready),
        .right_sink_data  (right_sink_data),
        .right_sink_valid (right_sink_valid),
        .right_sink_ready (right_sink_ready),
        .BCLK             (BCLK),
        .DACLRCK          (DACLRCK),
        .DACDAT           (DACDAT),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        left_sink_valid  = 1'b0;
        right_sink_valid = 1'b0;
        BCLK             = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
    endtask

    task automatic push(input logic left, input sample_t w);
        if (left) begin
            left_sink_data  = w;
            left_sink_valid = 1'b1;
        end else begin
            right_sink_data  = w;
            right_sink_valid = 1'b1;
        end
        wait_clk(1);
        left_sink_valid  = 1'b0;
        right_sink_valid = 1'b0;
    endtask

    // One BCLK period of 8 clk; LRCK moves with the rising edge, DACDAT sampled just before the next rise.
    task automatic bclk_period(input logic lr, output logic d);
        DACLRCK = lr;
        BCLK    = 1'b1;
        wait_clk(4);
        BCLK = 1'b0;
        wait_clk(4);
        d = DACDAT;
    endtask

    task automatic run_slot(input logic lr, input int n, output logic [63:0] bits);
        logic d;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            bclk_period(lr, d);
            bits[i] = d;
        end
    endtask

    function automatic logic [63:0] exp_slot(input sample_t w, input int n);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < n; i++) begin
`ifdef I2S_DAC_TX_LJ_EN
            if (i < DW) e[i] = w[DW-1-i];
`else
            if (i >= 1 && i <= DW) e[i] = w[DW-i];
`endif
        end
        return e;
    endfunction

    task automatic check_slot(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got bits %h expected %h", name, got, exp);
        end
    endtask

    task automatic prime();
        logic d;
        bclk_period(1'b1, d);
        tests_run++;
        if (d !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL prime_dacdat: got %b expected 0", d);
        end
    endtask

    task automatic test_reset();
        DACLRCK = 1'b1;
        do_reset();
        tests_run++;
        if (DACDAT !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dacdat: got %b expected 0", DACDAT);
        end
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_underflow: got %b expected 0", underflow);
        end
        tests_run++;
        if ({left_sink_ready, right_sink_ready} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 11", {left_sink_ready, right_sink_ready});
        end
    endtask

    task automatic test_basic();
        logic [63:0] bits;
        do_reset();
        push(1'b1, 24'hA5F00F);
        push(1'b0, 24'h123456);
        prime();
        run_slot(1'b0, 32, bits);
        check_slot("basic_left", bits, exp_slot(24'hA5F00F, 32));
        run_slot(1'b1, 32, bits);
        check_slot("basic_right", bits, exp_slot(24'h123456, 32));
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_underflow: got %b expected 0", underflow);
        end
    endtask

    task automatic test_fifo_full();
        sample_t     words [8];
        logic [63:0] bits;
        logic        d;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            words[k] = 24'((k + 1) * 24'h111111);
            push(1'b1, words[k]);
            if (k == 6) begin
                tests_run++;
                if (left_sink_ready !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL full_ready_7: got %b expected 1", left_sink_ready);
                end
            end
        end
        tests_run++;
        if (left_sink_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_ready_8: got %b expected 0", left_sink_ready);
        end
        left_sink_data  = 24'hDEAD99;
        left_sink_valid = 1'b1;
        wait_clk(2);
        left_sink_valid = 1'b0;
        tests_run++;
        if (left_sink_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_ready_9: got %b expected 0", left_sink_ready);
        end
        prime();
        DACLRCK = 1'b0;
        BCLK    = 1'b1;
        wait_clk(4);
        BCLK = 1'b0;
        wait_clk(2);
        tests_run++;
        if (left_sink_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_ready_after_pop: got %b expected 1", left_sink_ready);
        end
        wait_clk(2);
        d    = DACDAT;
        bits = '0;
        bits[0] = d;
        for (int i = 1; i < 26; i++) begin
            bclk_period(1'b0, d);
            bits[i] = d;
        end
        check_slot("full_word_0", bits, exp_slot(words[0], 26));
        for (int k = 1; k <= 8; k++) begin
            run_slot(1'b1, 26, bits);
            run_slot(1'b0, 26, bits);
            check_slot($sformatf("full_word_%0d", k), bits,
                       (k < 8) ? exp_slot(words[k], 26) : 64'd0);
        end
    endtask

    task automatic test_underflow();
        logic [63:0] bits;
        do_reset();
        push(1'b0, 24'h654321);
        prime();
        run_slot(1'b0, 4, bits);
        check_slot("under_left_zero", bits, 64'd0);
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL under_flag_set: got %b expected 1", underflow);
        end
        run_slot(1'b1, 26, bits);
        check_slot("under_right_indep", bits, exp_slot(24'h654321, 26));
        run_slot(1'b0, 4, bits);
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL under_flag_sticky: got %b expected 1", underflow);
        end
    endtask

    task automatic test_short_slot();
        logic [63:0] bits;
        do_reset();
        push(1'b1, 24'hABCDEF);
        push(1'b1, 24'h13579B);
        push(1'b0, 24'h2468AC);
        push(1'b0, 24'hC0FFEE);
        prime();
        run_slot(1'b0, 16, bits);
        check_slot("short_left", bits, exp_slot(24'hABCDEF, 16));
        run_slot(1'b1, 16, bits);
        check_slot("short_right", bits, exp_slot(24'h2468AC, 16));
        run_slot(1'b0, 32, bits);
        check_slot("short_left_next", bits, exp_slot(24'h13579B, 32));
        run_slot(1'b1, 32, bits);
        check_slot("short_right_next", bits, exp_slot(24'hC0FFEE, 32));
    endtask

    task automatic test_reset_mid();
        logic [63:0] bits;
        logic        d;
        do_reset();
        push(1'b1, 24'hFFFFFF);
        push(1'b1, 24'h222222);
        prime();
        run_slot(1'b0, 10, bits);
        do_reset();
        tests_run++;
        if ({DACDAT, underflow, left_sink_ready} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: got %b expected 001", {DACDAT, underflow, left_sink_ready});
        end
        push(1'b1, 24'h800001);
        bclk_period(1'b0, d);
        tests_run++;
        if (d !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_capture: got %b expected 0", d);
        end
        run_slot(1'b1, 6, bits);
        check_slot("midreset_quiet", bits, 64'd0);
        run_slot(1'b0, 26, bits);
        check_slot("midreset_word", bits, exp_slot(24'h800001, 26));
        run_slot(1'b1, 4, bits);
        run_slot(1'b0, 26, bits);
        check_slot("midreset_flushed", bits, 64'd0);
    endtask

`ifdef I2S_DAC_TX_LJ_EN
    task automatic test_lj_msb();
        logic [63:0] bits;
        do_reset();
        push(1'b1, 24'h800000);
        prime();
        run_slot(1'b0, 26, bits);
        check_slot("lj_msb", bits, 64'h1);
    endtask
`endif

    initial begin
        reset            = 1'b1;
        BCLK             = 1'b0;
        DACLRCK          = 1'b1;
        left_sink_data   = '0;
        right_sink_data  = '0;
        left_sink_valid  = 1'b0;
        right_sink_valid = 1'b0;
        wait_clk(2);
        test_reset();
        test_basic();
        test_fifo_full();
        test_underflow();
        test_short_slot();
        test_reset_mid();
`ifdef I2S_DAC_TX_LJ_EN
        test_lj_msb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
